digital_tx_sched: RTL and testbench

Frame scheduler that sits in front of digital_tx and sequences it. It captures one frame of up to MAX_WORDS words from a host stream into a local buffer. On i_go it loads the frame into digital_tx (valid beats plus word count), pulses tx_start and waits for tx_done. It repeats this for a programmed number of transmissions, with a programmable idle gap between them.

---
 rtl/digital_tx_sched.sv | 211 +++++++++++++++++++++
 tb/tb_digital_tx_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digital_tx_sched.sv
// digital_tx_sched - frame scheduler in front of digital_tx.
//
// Captures one frame (up to MAX_WORDS words) from a host valid/ready stream
// into a local buffer. On an accepted i_go, it streams the frame into
// digital_tx, pulses tx_start and waits for tx_done. This repeats i_repeat
// times (0 = until abort), with i_period idle cycles between transmissions.
//
// Optional feature macro: DIGITAL_TX_SCHED_WDT_EN
//   When defined, a watchdog aborts WAIT_DONE after TIMEOUT cycles and sets
//   the sticky o_timeout flag. Otherwise o_timeout is tied to 0.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_valid/s_ready/s_data/s_last   host frame stream (accepted only in IDLE)
//   i_go, i_abort                   start / abort pulses
//   i_repeat, i_period              transmission count and idle gap (sampled on go)
//   o_tx_valid/o_tx_data            word beats to digital_tx
//   o_tx_data_num                   frame word count to digital_tx
//   o_tx_start, i_tx_done           digital_tx start pulse / completion pulse
//   o_busy                          high outside IDLE
//   o_frame_cnt                     completed transmissions since last go
//   o_overflow, o_timeout           sticky status flags, cleared on accepted go
module digital_tx_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WORDS  = 64,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  i_go,
  input  logic                  i_abort,
  input  logic [15:0]           i_repeat,
  input  logic [31:0]           i_period,
  output logic                  o_tx_valid,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [31:0]           o_tx_data_num,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic [15:0]           o_frame_cnt,
  output logic                  o_overflow,
  output logic                  o_timeout
);

  localparam int AW = $clog2(MAX_WORDS);

  if (MAX_WORDS < 2 || (MAX_WORDS & (MAX_WORDS - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("digital_tx_sched: MAX_WORDS must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, GAP} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [MAX_WORDS];
  logic [AW:0]           word_cnt;      // words in the current frame
  logic                  frame_closed;  // frame ended (s_last or overflow)
  logic                  discarding;    // dropping overflow beats until s_last
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         rd_next;
  logic [AW-1:0]         wr_idx;
  logic [AW:0]           wr_cnt_nxt;
  logic [15:0]           repeat_q;
  logic [31:0]           period_q;
  logic [31:0]           gap_cnt;
  logic [15:0]           frame_cnt_inc;
  logic                  beat_acc;
  logic                  go_acc;
  logic                  done_acc;
  logic                  last_word;
  logic                  wdt_expired;

  assign beat_acc      = s_valid & s_ready;
  // A go on the same cycle as a capture beat is dropped: the frame is changing.
  assign go_acc        = (state == IDLE) & i_go & frame_closed & (word_cnt != '0)
                         & ~i_abort & ~beat_acc;
  assign done_acc      = (state == WAIT_DONE) & i_tx_done;
  assign frame_cnt_inc = o_frame_cnt + 16'd1;
  assign last_word     = (rd_ptr == AW'(word_cnt - (AW+1)'(1)));
  // Read address for the next cycle's beat; prefetching this way gives
  // back-to-back beats from a registered RAM read.
  assign rd_next       = (state == LOAD) ? rd_ptr + AW'(1) : '0;
  // The first beat after a closed frame restarts the buffer at word 0.
  assign wr_idx        = frame_closed ? '0 : word_cnt[AW-1:0];
  assign wr_cnt_nxt    = {1'b0, wr_idx} + (AW+1)'(1);

`ifdef DIGITAL_TX_SCHED_WDT_EN
  logic [31:0] wdt_cnt;

  assign wdt_expired = (wdt_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt   <= '0;
      o_timeout <= 1'b0;
    end else begin
      wdt_cnt <= (state == WAIT_DONE) ? wdt_cnt + 32'd1 : '0;
      if (go_acc)
        o_timeout <= 1'b0;
      else if (state == WAIT_DONE && !i_tx_done && wdt_expired)
        o_timeout <= 1'b1;
    end
  end
`else
  assign wdt_expired = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      IDLE:      if (go_acc) state_nxt = LOAD;
      LOAD:      if (last_word) state_nxt = START;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done) begin
          if (repeat_q != 16'd0 && frame_cnt_inc == repeat_q) state_nxt = IDLE;
          else if (period_q == 32'd0)                         state_nxt = LOAD;
          else                                                state_nxt = GAP;
        end else if (wdt_expired) begin
          state_nxt = IDLE;
        end
      end
      GAP:       if (gap_cnt == 32'd0) state_nxt = LOAD;
      default:   state_nxt = IDLE;
    endcase
    // Abort wins over everything; a coincident done is still counted below.
    if (i_abort && state != IDLE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready       <= 1'b0;
      o_busy        <= 1'b0;
      o_tx_valid    <= 1'b0;
      o_tx_start    <= 1'b0;
      o_tx_data_num <= '0;
      o_frame_cnt   <= '0;
      o_overflow    <= 1'b0;
      word_cnt      <= '0;
      frame_closed  <= 1'b0;
      discarding    <= 1'b0;
      rd_ptr        <= '0;
      repeat_q      <= '0;
      period_q      <= '0;
      gap_cnt       <= '0;
    end else begin
      // Control outputs are decoded from the next state so they align with it.
      s_ready    <= (state_nxt == IDLE);
      o_busy     <= (state_nxt != IDLE);
      o_tx_valid <= (state_nxt == LOAD);
      o_tx_start <= (state_nxt == START);

      if (state_nxt == LOAD) rd_ptr <= rd_next;

      if (state == GAP) gap_cnt <= gap_cnt - 32'd1;
      else              gap_cnt <= period_q - 32'd1;

      if (beat_acc) begin
        if (discarding) begin
          if (s_last) discarding <= 1'b0;
        end else begin
          word_cnt <= wr_cnt_nxt;
          if (s_last || wr_cnt_nxt == (AW+1)'(MAX_WORDS)) begin
            frame_closed <= 1'b1;
            if (!s_last) begin
              o_overflow <= 1'b1;
              discarding <= 1'b1;
            end
          end else begin
            frame_closed <= 1'b0;
          end
        end
      end

      if (go_acc) begin
        repeat_q      <= i_repeat;
        period_q      <= i_period;
        o_tx_data_num <= 32'(word_cnt);
        o_frame_cnt   <= '0;
        o_overflow    <= 1'b0;
      end

      if (done_acc) o_frame_cnt <= frame_cnt_inc;
    end
  end

  // NOTE: the buffer has no reset; its contents are meaningless until a
  // frame is captured, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (beat_acc && !discarding) mem[wr_idx] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  o_tx_data <= '0;
    else if (state_nxt == LOAD)  o_tx_data <= mem[rd_next];
  end

endmodule

// File: tb/tb_digital_tx_sched.sv
module tb_digital_tx_sched;

  localparam int DW = 32;
  localparam int MW = 8;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          i_go = 1'b0;
  logic          i_abort = 1'b0;
  logic [15:0]   i_repeat = '0;
  logic [31:0]   i_period = '0;
  logic          o_tx_valid;
  logic [DW-1:0] o_tx_data;
  logic [31:0]   o_tx_data_num;
  logic          o_tx_start;
  logic          i_tx_done = 1'b0;
  logic          o_busy;
  logic [15:0]   o_frame_cnt;
  logic          o_overflow;
  logic          o_timeout;

  always #5 clk = ~clk;

  digital_tx_sched #(.DATA_WIDTH(DW), .MAX_WORDS(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .i_go(i_go), .i_abort(i_abort), .i_repeat(i_repeat), .i_period(i_period),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .o_tx_data_num(o_tx_data_num),
    .o_tx_start(o_tx_start), .i_tx_done(i_tx_done), .o_busy(o_busy),
    .o_frame_cnt(o_frame_cnt), .o_overflow(o_overflow), .o_timeout(o_timeout)
  );

  int            checks = 0;
  int            errors = 0;
  int            starts = 0;
  logic [DW-1:0] exp_q[$];    // scoreboard of words expected on o_tx_data
  logic [DW-1:0] frame_m[$];  // model of the buffered frame
  logic [31:0]   exp_num = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard consumer: every beat must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && o_tx_valid) begin
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("beat_data", 64'(o_tx_data), 64'(exp_q.pop_front()));
      check("beat_data_num", 64'(o_tx_data_num), 64'(exp_num));
    end
    if (rst_n && o_tx_start) starts++;
  end

  task automatic send_beats(input logic [DW-1:0] w[$], input bit last);
    foreach (w[i]) begin
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = last && (i == w.size() - 1);
      check("s_ready_beat", 64'(s_ready), 64'd1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Accepted go: pushes the expected words for nrep transmissions.
  task automatic go(input logic [15:0] rep, input logic [31:0] per, input int nrep);
    for (int r = 0; r < nrep; r++)
      foreach (frame_m[i]) exp_q.push_back(frame_m[i]);
    exp_num  = 32'(frame_m.size());
    i_repeat = rep;
    i_period = per;
    i_go     = 1'b1;
    tick();
    i_go     = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (!o_tx_start && n < budget) begin
      tick();
      n++;
    end
    check("start_seen", 64'(o_tx_start), 64'd1);
  endtask

  task automatic run_done(input int delay);
    wait_start(100);
    repeat (delay) tick();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w[$];
    int n;
    int s0;

    // Reset state
    repeat (2) tick();
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_outputs", 64'({o_tx_valid, o_tx_start, o_busy, o_overflow, o_timeout}), 64'd0);
    check("rst_frame_cnt", 64'(o_frame_cnt), 64'd0);
    check("rst_data_num", 64'(o_tx_data_num), 64'd0);
    rst_n = 1'b1;
    tick();
    check("s_ready_after_rst", 64'(s_ready), 64'd1);

    // 1: two-word frame, single transmission
    w = '{32'h04030201, 32'h08070605};
    send_beats(w, 1'b1);
    frame_m = w;
    go(16'd1, 32'd0, 1);
    check("t1_valid_c1", 64'(o_tx_valid), 64'd1);
    check("t1_busy_c1", 64'(o_busy), 64'd1);
    check("t1_s_ready_busy", 64'(s_ready), 64'd0);
    tick();
    check("t1_valid_c2", 64'(o_tx_valid), 64'd1);
    check("t1_nostart_c2", 64'(o_tx_start), 64'd0);
    tick();
    check("t1_start_c3", 64'(o_tx_start), 64'd1);
    check("t1_valid_c3", 64'(o_tx_valid), 64'd0);
    tick();
    check("t1_start_c4", 64'(o_tx_start), 64'd0);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("t1_frame_cnt", 64'(o_frame_cnt), 64'd1);
    check("t1_idle", 64'(o_busy), 64'd0);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // 2: three transmissions with a 5-cycle gap
    go(16'd3, 32'd5, 3);
    for (int r = 0; r < 3; r++) begin
      wait_start(100);
      repeat (4) tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      check("t2_frame_cnt", 64'(o_frame_cnt), 64'(r + 1));
      if (r < 2) begin
        n = 0;
        while (!o_tx_valid && n < 20) begin
          check("t2_gap_busy", 64'(o_busy), 64'd1);
          n++;
          tick();
        end
        check("t2_gap_len", 64'(n), 64'd5);
      end
    end
    check("t2_idle", 64'(o_busy), 64'd0);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // 3: overflow, extra beats discarded
    w.delete();
    for (int i = 0; i < MW + 3; i++) w.push_back(32'h100 + 32'(i));
    send_beats(w, 1'b1);
    check("t3_overflow", 64'(o_overflow), 64'd1);
    frame_m.delete();
    for (int i = 0; i < MW; i++) frame_m.push_back(w[i]);
    go(16'd1, 32'd0, 1);
    check("t3_overflow_clr", 64'(o_overflow), 64'd0);
    check("t3_data_num", 64'(o_tx_data_num), 64'(MW));
    run_done(2);
    check("t3_frame_cnt", 64'(o_frame_cnt), 64'd1);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // 4: abort on 2nd LOAD beat, then full replay
    w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    send_beats(w, 1'b1);
    frame_m = w;
    go(16'd1, 32'd0, 1);
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("t4_valid_drop", 64'(o_tx_valid), 64'd0);
    check("t4_no_start", 64'(o_tx_start), 64'd0);
    check("t4_idle", 64'(o_busy), 64'd0);
    check("t4_beats_left", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    s0 = starts;
    repeat (3) tick();
    check("t4_no_start_after", 64'(starts), 64'(s0));
    go(16'd1, 32'd0, 1);
    run_done(2);
    check("t4_replay_cnt", 64'(o_frame_cnt), 64'd1);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);

    // 5: ignored go cases, ignored done, coincident done+abort
    w = '{32'hB0};
    send_beats(w, 1'b0);
    i_go = 1'b1;
    tick();
    i_go = 1'b0;
    tick();
    check("t5_go_open_frame", 64'(o_busy), 64'd0);
    w = '{32'hB1};
    send_beats(w, 1'b1);
    frame_m = '{32'hB0, 32'hB1};
    s0 = starts;
    go(16'd1, 32'd0, 1);
    i_go = 1'b1;
    i_repeat = 16'd5;
    tick();
    i_go = 1'b0;
    run_done(1);
    check("t5_busy_go_cnt", 64'(o_frame_cnt), 64'd1);
    check("t5_busy_go_idle", 64'(o_busy), 64'd0);
    check("t5_one_start", 64'(starts - s0), 64'd1);
    // go coincident with a capture beat
    s_valid = 1'b1;
    s_data  = 32'hC0;
    s_last  = 1'b1;
    i_go    = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    i_go    = 1'b0;
    tick();
    check("t5_go_on_beat", 64'(o_busy), 64'd0);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    check("t5_done_in_idle", 64'(o_frame_cnt), 64'd1);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("t5_abort_in_idle", 64'(s_ready), 64'd1);
    frame_m = '{32'hC0};
    go(16'd0, 32'd0, 1);
    wait_start(100);
    tick();
    i_tx_done = 1'b1;
    i_abort   = 1'b1;
    tick();
    i_tx_done = 1'b0;
    i_abort   = 1'b0;
    check("t5_done_abort_cnt", 64'(o_frame_cnt), 64'd1);
    check("t5_done_abort_idle", 64'(o_busy), 64'd0);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef DIGITAL_TX_SCHED_WDT_EN
    // 6: watchdog expiry in WAIT_DONE
    go(16'd1, 32'd0, 1);
    wait_start(100);
    n = 0;
    while (o_busy && n < 3 * TO) begin
      tick();
      n++;
    end
    check("t6_wdt_cycles", 64'(n), 64'(TO + 1));
    check("t6_timeout", 64'(o_timeout), 64'd1);
    check("t6_frame_cnt", 64'(o_frame_cnt), 64'd0);
    go(16'd1, 32'd0, 1);
    check("t6_timeout_clr", 64'(o_timeout), 64'd0);
    run_done(1);
`else
    check("t6_timeout_tied", 64'(o_timeout), 64'd0);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
